// File: rtl/cpu_pkg.sv
// Shared types and encodings for the simple RISC CPU controller.
// Holds the control-FSM state enum, opcode/op fields, vsel and ALU codes.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_GET_A,
      S_GET_B,
      S_EXEC,
      S_WRITE_REG,
      S_WRITE_IMM
   } state_t;

   localparam logic [2:0] OPC_ALU = 3'b101;
   localparam logic [2:0] OPC_MOV = 3'b110;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   localparam logic [1:0] VSEL_MDATA = 2'b00;
   localparam logic [1:0] VSEL_IMM   = 2'b01;
   localparam logic [1:0] VSEL_PC    = 2'b10;
   localparam logic [1:0] VSEL_C     = 2'b11;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_AND   = 2'b10;
   localparam logic [1:0] ALU_NOT_B = 2'b11;

   // First state after S_DECODE; S_WAIT doubles as the illegal-instruction marker.
   function automatic state_t decode_next(input logic [2:0] opcode, input logic [1:0] op);
      if (opcode == OPC_MOV && op == OP_MOV_IMM) return S_WRITE_IMM;
      if (opcode == OPC_MOV && op == OP_MOV_REG) return S_GET_B;
      if (opcode == OPC_ALU && op == OP_MVN)     return S_GET_B;
      if (opcode == OPC_ALU)                     return S_GET_A;
      return S_WAIT;
   endfunction

endpackage

// File: rtl/insn_decoder.sv
// Combinational field extraction and immediate sign extension from the IR.
module insn_decoder
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [15:0]       ir,
   output logic [2:0]        opcode,
   output logic [1:0]        op,
   output logic [2:0]        rn,
   output logic [2:0]        rd,
   output logic [1:0]        sh,
   output logic [2:0]        rm,
   output logic [DATA_W-1:0] sximm8,
   output logic [DATA_W-1:0] sximm5
);

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];

   assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
   assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};

endmodule

// File: rtl/cpu_controller.sv
// Instruction register, decoder and control FSM for the 16-bit RISC CPU.
// Build option CPU_CTRL_ILLEGAL_TRAP_EN: sticky err on illegal decode, halts until reset.
//
// state       | meaning
// S_WAIT      | idle, w=1, accepts load/s
// S_DECODE    | pick path from opcode/op, illegal codes return to S_WAIT
// S_GET_A     | read Rn into A
// S_GET_B     | read Rm into B
// S_EXEC      | shift + ALU, load C (or status for CMP)
// S_WRITE_REG | write C into Rd
// S_WRITE_IMM | write sximm8 into Rn
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s,
   input  logic              load,
   input  logic [15:0]       in,
   output logic              w,
   output logic [2:0]        readnum,
   output logic [2:0]        writenum,
   output logic              write,
   output logic [1:0]        vsel,
   output logic              loada,
   output logic              loadb,
   output logic              asel,
   output logic              bsel,
   output logic [1:0]        shift,
   output logic [1:0]        ALUop,
   output logic              loadc,
   output logic              loads,
   output logic [DATA_W-1:0] sximm8,
   output logic [DATA_W-1:0] sximm5,
   output logic              err
);

   state_t      state_q, state_d;
   logic [15:0] ir_q;
   logic [2:0]  opcode, rn, rd, rm;
   logic [1:0]  op, sh;

   insn_decoder #(.DATA_W(DATA_W)) u_insn_decoder (
      .ir     (ir_q),
      .opcode (opcode),
      .op     (op),
      .rn     (rn),
      .rd     (rd),
      .sh     (sh),
      .rm     (rm),
      .sximm8 (sximm8),
      .sximm5 (sximm5)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_WAIT;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         if (load && state_q == S_WAIT) ir_q <= in;
      end
   end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else if (state_q == S_DECODE && decode_next(opcode, op) == S_WAIT)
         err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      w        = 1'b0;
      readnum  = 3'd0;
      writenum = 3'd0;
      write    = 1'b0;
      vsel     = VSEL_MDATA;
      loada    = 1'b0;
      loadb    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      shift    = 2'b00;
      ALUop    = ALU_ADD;
      loadc    = 1'b0;
      loads    = 1'b0;

      case (state_q)
         S_WAIT: begin
            w = 1'b1;
            if (s && !err) state_d = S_DECODE;
         end
         S_DECODE: state_d = decode_next(opcode, op);
         S_GET_A: begin
            readnum = rn;
            loada   = 1'b1;
            state_d = S_GET_B;
         end
         S_GET_B: begin
            readnum = rm;
            loadb   = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            shift = sh;
            // MOV reg passes B through the adder with A forced to zero
            if (opcode == OPC_ALU) begin
               ALUop = op;
            end else begin
               ALUop = ALU_ADD;
               asel  = 1'b1;
            end
            if (opcode == OPC_ALU && op == OP_CMP) begin
               loads   = 1'b1;
               state_d = S_WAIT;
            end else begin
               loadc   = 1'b1;
               state_d = S_WRITE_REG;
            end
         end
         S_WRITE_REG: begin
            writenum = rd;
            vsel     = VSEL_C;
            write    = 1'b1;
            state_d  = S_WAIT;
         end
         S_WRITE_IMM: begin
            writenum = rn;
            vsel     = VSEL_IMM;
            write    = 1'b1;
            state_d  = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase
   end

endmodule
